// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory access front end.
// Holds the size codes, the FSM state type and the store-lane helper functions.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R,
        ST_RESP
    } dmem_state_t;

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] data;
    } store_lane_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Replicates the LSB-justified store data across every lane it could land in,
    // so the byte enables alone select the bytes the memory writes.
    function automatic store_lane_t store_lanes(input logic [1:0]  size,
                                                input logic [1:0]  addr_lo,
                                                input logic [31:0] wdata);
        store_lane_t r;
        r.mask = 4'b0000;
        r.data = wdata;
        case (size)
            SZ_BYTE: begin
                r.mask = 4'b0001 << addr_lo;
                r.data = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                r.mask = 4'b0011 << {addr_lo[1], 1'b0};
                r.data = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                r.mask = 4'b1111;
            end
            default: begin
                r.mask = 4'b0000;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_access_unit_store_align.sv
// Combinational alignment check plus byte-mask and lane-replication for stores.
module store_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_rep,
    output logic        misaligned
);

    store_lane_t lanes;

    assign lanes      = store_lanes(size, addr_lo, wdata);
    assign wmask      = lanes.mask;
    assign wdata_rep  = lanes.data;
    assign misaligned = is_misaligned(size, addr_lo);

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage front end: accepts one load/store, runs the bus handshake,
// captures load data for load_unit and reports misalignment or bus timeout.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req_valid_in,
    input  logic              req_we_in,
    input  logic [1:0]        req_size_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic [31:0]       req_wdata_in,
    output logic              req_ready_o,
    output logic              stall_o,
    output logic              dm_req_o,
    output logic              dm_we_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [31:0]       dm_wdata_o,
    output logic [3:0]        dm_wmask_o,
    input  logic              dm_gnt_in,
    input  logic              dm_rvalid_in,
    input  logic [31:0]       dm_rdata_in,
    output logic [31:0]       dm_data_o,
    output logic [1:0]        iadder_out_1to0_o,
    output logic              rsp_valid_o,
    output logic              misaligned_o,
    output logic              bus_err_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        mask_q;
    logic [31:0]       wrep_q;
    logic              mis_q;
    logic              berr_q;
    logic [31:0]       data_q;

    logic [3:0]        align_mask;
    logic [31:0]       align_wdata;
    logic              align_mis;
    logic              accept;
    logic              timeout_hit;
    logic              timeout_abort;

    // Alignment is evaluated on the incoming request so IDLE can branch straight to RESP.
    store_align u_store_align (
        .size       (req_size_in),
        .addr_lo    (req_addr_in[1:0]),
        .wdata      (req_wdata_in),
        .wmask      (align_mask),
        .wdata_rep  (align_wdata),
        .misaligned (align_mis)
    );

    assign accept      = (state_q == ST_IDLE) && req_valid_in;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        timeout_abort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_in) begin
                    state_d = align_mis ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                // Any rvalid seen alongside the grant is ignored; read data always follows later.
                if (dm_gnt_in) begin
                    state_d = we_q ? ST_RESP : ST_WAIT_R;
                end else if (timeout_hit) begin
                    state_d       = ST_RESP;
                    timeout_abort = 1'b1;
                end
            end
            ST_WAIT_R: begin
                if (dm_rvalid_in) begin
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    state_d       = ST_RESP;
                    timeout_abort = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            mask_q  <= 4'b0000;
            wrep_q  <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            // Counter restarts on every state change so it measures time in REQ or WAIT_R alone.
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (accept) begin
                we_q   <= req_we_in;
                addr_q <= req_addr_in;
                mask_q <= align_mask;
                wrep_q <= align_wdata;
                mis_q  <= align_mis;
                berr_q <= 1'b0;
            end
            if (timeout_abort) begin
                berr_q <= 1'b1;
            end
            if ((state_q == ST_WAIT_R) && dm_rvalid_in) begin
                data_q <= dm_rdata_in;
            end
        end
    end

    assign req_ready_o       = (state_q == ST_IDLE);
    assign stall_o           = (state_q != ST_IDLE);
    assign dm_req_o          = (state_q == ST_REQ);
    assign dm_we_o           = (state_q == ST_REQ) && we_q;
    assign dm_addr_o         = {addr_q[ADDR_W-1:2], 2'b00};
    assign dm_wdata_o        = wrep_q;
    assign dm_wmask_o        = we_q ? mask_q : 4'b0000;
    assign dm_data_o         = data_q;
    assign iadder_out_1to0_o = addr_q[1:0];
    assign rsp_valid_o       = (state_q == ST_RESP);
    assign misaligned_o      = (state_q == ST_RESP) && mis_q;
    assign bus_err_o         = (state_q == ST_RESP) && berr_q;

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
Memory-stage front end that sits directly upstream of load_unit. It accepts one load or store request at a time from execute and checks alignment. It drives a word-addressed data-memory bus with a request/grant handshake and produces store byte masks with lane-replicated write data. For loads it captures the returned word and presents it, with address bits [1:0], to load_unit. It stalls the pipeline while a transaction is outstanding and reports bus timeouts.

Parameters:
TIMEOUT, 16, max cycles spent in REQ or WAIT_R before abort; 0 disables timeout
ADDR_W, 32, byte-address width

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
req_valid_in  input  1  execute presents a memory op
req_we_in  input  1  1=store, 0=load
req_size_in  input  2  00 byte, 01 half, 10 word, 11 illegal
req_addr_in  input  ADDR_W  byte address (iadder result)
req_wdata_in  input  32  store data, LSB-justified
req_ready_o  output  1  high only in IDLE; request accepted on valid&ready
stall_o  output  1  high whenever state != IDLE
dm_req_o  output  1  bus request
dm_we_o  output  1  bus write enable
dm_addr_o  output  ADDR_W  word-aligned address, bits [1:0]=00
dm_wdata_o  output  32  lane-replicated store data
dm_wmask_o  output  4  byte enables; 0000 for loads
dm_gnt_in  input  1  bus accepts request this cycle
dm_rvalid_in  input  1  read data valid
dm_rdata_in  input  32  read data word
dm_data_o  output  32  captured load word, goes to load_unit dm_data_in
iadder_out_1to0_o  output  2  latched addr[1:0], goes to load_unit
rsp_valid_o  output  1  one-cycle completion pulse
misaligned_o  output  1  qualifies rsp_valid_o: alignment/size fault
bus_err_o  output  1  qualifies rsp_valid_o: timeout

Behaviour:
- Reset: state=IDLE. Every output is 0 except req_ready_o=1. Registers cleared; dm_data_o=0.
- States: IDLE, REQ, WAIT_R, RESP.
- IDLE: on req_valid_in, latch we, size, addr and wdata, then check alignment. Misaligned means half with addr[0]=1, word with addr[1:0]!=00, or size 11. Misaligned goes to RESP with misaligned_o=1 and no bus activity. Otherwise go to REQ.
- REQ: dm_req_o=1 with the latched fields held stable until grant. On dm_gnt_in, a store goes to RESP and a load goes to WAIT_R.
- WAIT_R: on dm_rvalid_in, capture dm_rdata_in into dm_data_o and go to RESP. dm_data_o holds its value until the next load capture.
- RESP: rsp_valid_o=1 for exactly one cycle, then IDLE. misaligned_o and bus_err_o are meaningful only in RESP.
- Latency, request to rsp_valid_o: store with immediate grant = 2 cycles; load with immediate grant and rvalid on the next cycle = 3 cycles; misaligned = 1 cycle.
- Mask and data generation:
  - byte: mask 0001<<addr[1:0], wdata {4{wdata[7:0]}}
  - half: mask 0011<<{addr[1],1'b0}, wdata {2{wdata[15:0]}}
  - word: mask 1111, wdata unchanged
- iadder_out_1to0_o is the latched addr[1:0], stable from acceptance until the next acceptance.
- dm_rvalid_in outside WAIT_R is ignored. A grant and rvalid arriving in the same cycle while in REQ: rvalid is ignored, because the bus contract is that rvalid comes at least one cycle after grant.
- Timeout: a counter resets on entry to REQ or WAIT_R and increments each cycle spent there. When it reaches TIMEOUT, drop dm_req_o, go to RESP and set bus_err_o=1. A late rvalid is ignored once back in IDLE.
- Back-to-back: a new request is accepted only in IDLE, so the minimum gap between acceptances is the transaction latency plus one.
- Reset mid-operation: abort immediately. dm_req_o drops in the cycle after rst_in is sampled. No rsp_valid_o is issued.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum dmem_state_t
  - function for the alignment check
  - function for mask/replication, shared with testbench models
- One sub-module, store_align: purely combinational; (size, addr[1:0], wdata) -> (wmask, wdata_rep, misaligned).

Test Plan:
- Store byte: addr 0x1003, wdata 0x000000AB, immediate grant -> dm_addr_o 0x1000, wmask 1000, wdata 0xABABABAB; rsp_valid_o 2 cycles after acceptance.
- Load half: addr 0x2002, grant after 3 cycles, rvalid 1 cycle later with 0xBEEF1234 -> dm_data_o 0xBEEF1234, iadder_out_1to0_o 10, stall_o high throughout, single rsp_valid_o pulse.
- Misaligned: word load at 0x3001 -> dm_req_o never asserted; misaligned_o=1 and rsp_valid_o=1 one cycle after acceptance. Size 11 gives the same result.
- Timeout (TIMEOUT=4): grant never asserted -> dm_req_o high 4 cycles then low; bus_err_o and rsp_valid_o pulse; back to IDLE. A stray rvalid afterwards leaves dm_data_o unchanged.
- Reset in WAIT_R: assert rst_in -> next cycle all outputs at reset values, req_ready_o=1, no rsp_valid_o pulse.
- Back-to-back: store word 0x4000 (data 0xDEADBEEF), then a load held valid -> second request accepted only after rsp_valid_o; wmask 0000 for the load.
